// File: rtl/id_ex_reg_if.sv
// ID/EX stage bundle: decode-side inputs, WB write-port snoop, and registered EX outputs.
// master = upstream/control side, slave = the pipeline register itself.
interface id_ex_reg_if #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
);
  logic                STALL;
  logic                FLUSH;
  logic                ID_VALID;
  logic [4:0]          ID_RD_REG1;
  logic [4:0]          ID_RD_REG2;
  logic [XLEN-1:0]     ID_RD_DATA1;
  logic [XLEN-1:0]     ID_RD_DATA2;
  logic [XLEN-1:0]     ID_IMM;
  logic [XLEN-1:0]     ID_PC;
  logic [4:0]          ID_WR_REG;
  logic                ID_REG_WRITE;
  logic                ID_MEM_READ;
  logic                ID_MEM_WRITE;
  logic                ID_ALU_SRC;
  logic                ID_MEM_TO_REG;
  logic [ALU_OP_W-1:0] ID_ALU_OP;
  logic                WB_REG_WRITE;
  logic [4:0]          WB_WR_REG;
  logic [XLEN-1:0]     WB_WR_DATA;
  logic                HAZARD;
  logic                EX_VALID;
  logic [4:0]          EX_RD_REG1;
  logic [4:0]          EX_RD_REG2;
  logic [4:0]          EX_WR_REG;
  logic [XLEN-1:0]     EX_DATA1;
  logic [XLEN-1:0]     EX_DATA2;
  logic [XLEN-1:0]     EX_IMM;
  logic [XLEN-1:0]     EX_PC;
  logic                EX_REG_WRITE;
  logic                EX_MEM_READ;
  logic                EX_MEM_WRITE;
  logic                EX_ALU_SRC;
  logic                EX_MEM_TO_REG;
  logic [ALU_OP_W-1:0] EX_ALU_OP;

  modport master (
    output STALL, FLUSH, ID_VALID, ID_RD_REG1, ID_RD_REG2, ID_RD_DATA1, ID_RD_DATA2,
           ID_IMM, ID_PC, ID_WR_REG, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
           ID_ALU_SRC, ID_MEM_TO_REG, ID_ALU_OP, WB_REG_WRITE, WB_WR_REG, WB_WR_DATA,
    input  HAZARD, EX_VALID, EX_RD_REG1, EX_RD_REG2, EX_WR_REG, EX_DATA1, EX_DATA2,
           EX_IMM, EX_PC, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_ALU_SRC,
           EX_MEM_TO_REG, EX_ALU_OP
  );

  modport slave (
    input  STALL, FLUSH, ID_VALID, ID_RD_REG1, ID_RD_REG2, ID_RD_DATA1, ID_RD_DATA2,
           ID_IMM, ID_PC, ID_WR_REG, ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE,
           ID_ALU_SRC, ID_MEM_TO_REG, ID_ALU_OP, WB_REG_WRITE, WB_WR_REG, WB_WR_DATA,
    output HAZARD, EX_VALID, EX_RD_REG1, EX_RD_REG2, EX_WR_REG, EX_DATA1, EX_DATA2,
           EX_IMM, EX_PC, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_ALU_SRC,
           EX_MEM_TO_REG, EX_ALU_OP
  );
endinterface

// File: rtl/id_ex_reg.sv
// LEGv8 ID/EX pipeline register with WB write-through bypass, load-use bubble
// insertion, stall hold (with operand refresh) and flush.
module id_ex_reg #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
) (
  input  logic        CLK,
  input  logic        RST,
  id_ex_reg_if.slave  bus
);
  localparam logic [4:0] XZR = 5'd31;

  logic [XLEN-1:0] byp1, byp2;
  logic            refresh1, refresh2;
  logic            clear;

  // The register file only commits at the edge, so a same-cycle WB write must be forwarded.
  always_comb begin
    byp1 = bus.ID_RD_DATA1;
    byp2 = bus.ID_RD_DATA2;
    if (bus.WB_REG_WRITE && bus.WB_WR_REG == bus.ID_RD_REG1 && bus.ID_RD_REG1 != XZR)
      byp1 = bus.WB_WR_DATA;
    if (bus.WB_REG_WRITE && bus.WB_WR_REG == bus.ID_RD_REG2 && bus.ID_RD_REG2 != XZR)
      byp2 = bus.WB_WR_DATA;
  end

  assign bus.HAZARD = bus.EX_VALID && bus.EX_MEM_READ && (bus.EX_WR_REG != XZR) &&
                      bus.ID_VALID &&
                      ((bus.EX_WR_REG == bus.ID_RD_REG1) || (bus.EX_WR_REG == bus.ID_RD_REG2));

  assign refresh1 = bus.WB_REG_WRITE && (bus.WB_WR_REG == bus.EX_RD_REG1) && (bus.EX_RD_REG1 != XZR);
  assign refresh2 = bus.WB_REG_WRITE && (bus.WB_WR_REG == bus.EX_RD_REG2) && (bus.EX_RD_REG2 != XZR);

  // A load-use bubble only applies when the stage is actually advancing.
  assign clear = RST || bus.FLUSH || (!bus.STALL && bus.HAZARD);

  always_ff @(posedge CLK) begin
    if (clear) begin
      bus.EX_VALID      <= 1'b0;
      bus.EX_RD_REG1    <= 5'd0;
      bus.EX_RD_REG2    <= 5'd0;
      bus.EX_WR_REG     <= 5'd0;
      bus.EX_DATA1      <= '0;
      bus.EX_DATA2      <= '0;
      bus.EX_IMM        <= '0;
      bus.EX_PC         <= '0;
      bus.EX_REG_WRITE  <= 1'b0;
      bus.EX_MEM_READ   <= 1'b0;
      bus.EX_MEM_WRITE  <= 1'b0;
      bus.EX_ALU_SRC    <= 1'b0;
      bus.EX_MEM_TO_REG <= 1'b0;
      bus.EX_ALU_OP     <= {ALU_OP_W{1'b0}};
    end else if (bus.STALL) begin
      if (refresh1) bus.EX_DATA1 <= bus.WB_WR_DATA;
      if (refresh2) bus.EX_DATA2 <= bus.WB_WR_DATA;
    end else begin
      bus.EX_VALID      <= bus.ID_VALID;
      bus.EX_RD_REG1    <= bus.ID_RD_REG1;
      bus.EX_RD_REG2    <= bus.ID_RD_REG2;
      bus.EX_WR_REG     <= bus.ID_WR_REG;
      bus.EX_DATA1      <= byp1;
      bus.EX_DATA2      <= byp2;
      bus.EX_IMM        <= bus.ID_IMM;
      bus.EX_PC         <= bus.ID_PC;
      bus.EX_REG_WRITE  <= bus.ID_REG_WRITE && bus.ID_VALID;
      bus.EX_MEM_READ   <= bus.ID_MEM_READ  && bus.ID_VALID;
      bus.EX_MEM_WRITE  <= bus.ID_MEM_WRITE && bus.ID_VALID;
      bus.EX_ALU_SRC    <= bus.ID_ALU_SRC;
      bus.EX_MEM_TO_REG <= bus.ID_MEM_TO_REG;
      bus.EX_ALU_OP     <= bus.ID_ALU_OP;
    end
  end
endmodule
